// File: rtl/gate_pkg.sv
// Shared types and constants for the gate arbiter slice.
package gate_pkg;

  localparam int unsigned DW       = 4;
  localparam int unsigned NREQ_DEF = 4;

  typedef enum logic [2:0] {
    OP_BUF  = 3'd0,
    OP_NOT  = 3'd1,
    OP_AND  = 3'd2,
    OP_NAND = 3'd3,
    OP_OR   = 3'd4,
    OP_NOR  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_t;

endpackage

// File: rtl/gates.sv
// Shared 4-bit logic unit: every gate function computed in parallel.
module gates
  import gate_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y_buf,
  output logic [DW-1:0] y_not,
  output logic [DW-1:0] y_and,
  output logic [DW-1:0] y_nand,
  output logic [DW-1:0] y_or,
  output logic [DW-1:0] y_nor,
  output logic [DW-1:0] y_xor,
  output logic [DW-1:0] y_xnor
);

  assign y_buf  = a;
  assign y_not  = ~a;
  assign y_and  = a & b;
  assign y_nand = ~(a & b);
  assign y_or   = a | b;
  assign y_nor  = ~(a | b);
  assign y_xor  = a ^ b;
  assign y_xnor = ~(a ^ b);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic found;
  int   idx;

  // Scan requesters in priority order starting at ptr, wrapping mod NREQ.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = int'(ptr) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      if (en && !found && req[IDW'(idx)]) begin
        gnt[IDW'(idx)] = 1'b1;
        gnt_id         = IDW'(idx);
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin front end sharing one gates unit among NREQ requesters.
module gate_arbiter
  import gate_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0][2:0]     req_op,
  input  logic [NREQ-1:0][DW-1:0]  req_a,
  input  logic [NREQ-1:0][DW-1:0]  req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     resp_valid,
  output logic [IDW-1:0]           resp_id,
  output logic [DW-1:0]            resp_y,
  input  logic                     resp_ready,
  output logic [15:0]              grant_cnt
);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_nxt;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            granted;
  logic            stall;
  op_t             sel_op;
  logic [DW-1:0]   sel_a, sel_b;
  logic [DW-1:0]   y_buf, y_not, y_and, y_nand, y_or, y_nor, y_xor, y_xnor;
  logic [DW-1:0]   y_sel;

  // A held, unconsumed result blocks any new grant.
  assign stall     = resp_valid && !resp_ready;
  assign req_ready = gnt;
  assign granted   = |gnt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr),
    .en     (!stall),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign sel_op = op_t'(req_op[gnt_id]);
  assign sel_a  = req_a[gnt_id];
  assign sel_b  = req_b[gnt_id];

  gates u_gates (
    .a      (sel_a),
    .b      (sel_b),
    .y_buf  (y_buf),
    .y_not  (y_not),
    .y_and  (y_and),
    .y_nand (y_nand),
    .y_or   (y_or),
    .y_nor  (y_nor),
    .y_xor  (y_xor),
    .y_xnor (y_xnor)
  );

  // Pick the gates output matching the granted opcode.
  always_comb begin
    y_sel = y_buf;
    case (sel_op)
      OP_BUF:  y_sel = y_buf;
      OP_NOT:  y_sel = y_not;
      OP_AND:  y_sel = y_and;
      OP_NAND: y_sel = y_nand;
      OP_OR:   y_sel = y_or;
      OP_NOR:  y_sel = y_nor;
      OP_XOR:  y_sel = y_xor;
      OP_XNOR: y_sel = y_xnor;
      default: y_sel = y_buf;
    endcase
  end

  // Priority moves to the requester just after the winner.
  always_comb begin
    ptr_nxt = gnt_id + IDW'(1);
    if (gnt_id == IDW'(NREQ - 1)) ptr_nxt = '0;
  end

  // Result register, pointer and transaction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_y     <= '0;
      grant_cnt  <= '0;
    end else if (granted) begin
      ptr        <= ptr_nxt;
      resp_valid <= 1'b1;
      resp_id    <= gnt_id;
      resp_y     <= y_sel;
      grant_cnt  <= grant_cnt + 16'd1;
    end else if (!stall) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gate_arbiter.sv
// Self-checking bench for gate_arbiter against a behavioural model.
module tb_gate_arbiter;

  localparam int NREQ = 4;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][2:0] req_op;
  logic [NREQ-1:0][3:0] req_a;
  logic [NREQ-1:0][3:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 resp_valid;
  logic [1:0]           resp_id;
  logic [3:0]           resp_y;
  logic                 resp_ready;
  logic [15:0]          grant_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  int         m_ptr;
  bit         m_rv;
  int         m_id;
  logic [3:0] m_y;
  int         m_cnt;

  gate_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .resp_ready (resp_ready),
    .grant_cnt  (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] gate_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return a;
      3'd1: return ~a;
      3'd2: return a & b;
      3'd3: return ~(a & b);
      3'd4: return a | b;
      3'd5: return ~(a | b);
      3'd6: return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // Winner index or -1 given current inputs and model state.
  function automatic int pick();
    if (m_rv && !resp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i = (m_ptr + k) % NREQ;
      if (req_valid[2'(i)]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_rv = 0; m_id = 0; m_y = 4'h0; m_cnt = 0;
  endtask

  // One clock: inputs already driven after a negedge.
  task automatic cycle(input bit chk_en);
    int         w;
    logic [3:0] exp_rdy;
    #1;
    w = pick();
    exp_rdy = (w >= 0) ? 4'(1 << w) : 4'b0000;
    if (chk_en) chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (w >= 0) begin
      m_rv  = 1;
      m_id  = w;
      m_y   = gate_fn(req_op[2'(w)], req_a[2'(w)], req_b[2'(w)]);
      m_cnt = (m_cnt + 1) % 65536;
      m_ptr = (w + 1) % NREQ;
    end else if (!(m_rv && !resp_ready)) begin
      m_rv = 0;
    end
    #1;
    if (chk_en) begin
      chk("resp_valid", 32'(resp_valid), 32'(m_rv));
      chk("resp_id",    32'(resp_id),    32'(m_id));
      chk("resp_y",     32'(resp_y),     32'(m_y));
      chk("grant_cnt",  32'(grant_cnt),  32'(m_cnt));
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id",    32'(resp_id),    32'd0);
    chk("rst_resp_y",     32'(resp_y),     32'd0);
    chk("rst_grant_cnt",  32'(grant_cnt),  32'd0);
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    reset = 1'b0;

    // single request: req 2 AND 1100 & 1010
    req_valid = 4'b0100; req_op[2] = 3'd2; req_a[2] = 4'b1100; req_b[2] = 4'b1010;
    cycle(1);
    chk("single_y", 32'(resp_y), 32'b1000);
    req_valid = '0;
    cycle(1);

    // full round robin: XOR with a=i, b=1111
    pulse_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_op[i] = 3'd6; req_a[i] = 4'(i); req_b[i] = 4'b1111;
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) cycle(1);
    chk("rr_last_id", 32'(resp_id), 32'd0);
    req_valid = '0;
    cycle(1);

    // back-pressure: req 1 NOR 0000,0000 then hold resp_ready low
    req_valid = 4'b0010; req_op[1] = 3'd5; req_a[1] = 4'b0000; req_b[1] = 4'b0000;
    cycle(1);
    chk("bp_y", 32'(resp_y), 32'b1111);
    resp_ready = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) cycle(1);
    resp_ready = 1'b1;
    cycle(1);
    req_valid = '0;
    cycle(1);

    // all opcodes from requester 0
    for (int op = 0; op < 8; op++) begin
      req_valid = 4'b0001; req_op[0] = 3'(op); req_a[0] = 4'b0110; req_b[0] = 4'b0011;
      cycle(1);
    end
    req_valid = '0;
    cycle(1);

    // reset mid-operation with resp_valid=1 and ptr=3
    pulse_reset();
    req_valid = 4'b0100;
    cycle(1);
    req_valid = '0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_id",    32'(resp_id),    32'd0);
    chk("mid_rst_y",     32'(resp_y),     32'd0);
    chk("mid_rst_cnt",   32'(grant_cnt),  32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b1010;
    cycle(1);
    chk("post_rst_id", 32'(resp_id), 32'd1);
    req_valid = '0;
    cycle(1);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      req_valid  = 4'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        req_op[i] = 3'($urandom); req_a[i] = 4'($urandom); req_b[i] = 4'($urandom);
      end
      cycle(1);
    end

    // counter wrap after 65536 grants
    resp_ready = 1'b1; req_valid = '0;
    cycle(1);
    pulse_reset();
    req_valid = 4'b0001; req_op[0] = 3'd0; req_a[0] = 4'b1010;
    for (int n = 0; n < 65536; n++) cycle(0);
    chk("wrap_cnt", 32'(grant_cnt), 32'd0);
    req_valid = '0;
    cycle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
